// File: rtl/stage_ex.sv
// rtl/stage_ex.sv - execute stage: ALU, NZCV flags register, branch resolution, EX/MEM register
module stage_ex #(
  parameter int N = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         Stall_i,
  input  logic         Valid_i,
  input  logic [N-1:0] RD1_i,
  input  logic [N-1:0] RD2_i,
  input  logic [N-1:0] Extend_i,
  input  logic [3:0]   A3_i,
  input  logic         RF_WE_i,
  input  logic         MemWE_i,
  input  logic         WBSelect_i,
  input  logic         SetFlags_i,
  input  logic         BranchSelect_i,
  input  logic         ALUOpBSelect_i,
  input  logic [1:0]   ALUControl_i,
  output logic         BranchTaken_o,
  output logic [N-1:0] BranchTarget_o,
  output logic [N-1:0] ALUResult_o,
  output logic [N-1:0] WriteData_o,
  output logic [3:0]   A3_o,
  output logic         RF_WE_o,
  output logic         MemWE_o,
  output logic         WBSelect_o,
  output logic         Valid_o,
  output logic [3:0]   Flags_o
);

  logic [N-1:0] w_opb;
  logic [N-1:0] w_opb_x;
  logic [N:0]   w_sum;
  logic         w_sub;
  logic [N-1:0] w_res;
  logic         w_c;
  logic         w_v;
  logic         w_cond;
  logic [3:0]   r_flags;

  assign w_opb   = ALUOpBSelect_i ? Extend_i : RD2_i;
  assign w_sub   = (ALUControl_i == 2'b01);
  // Subtract as A + ~B + 1 so the adder carry-out is directly NOT borrow.
  assign w_opb_x = w_sub ? ~w_opb : w_opb;
  assign w_sum   = {1'b0, RD1_i} + {1'b0, w_opb_x} + {{N{1'b0}}, w_sub};

  always_comb begin
    w_res = w_sum[N-1:0];
    w_c   = w_sum[N];
    w_v   = (RD1_i[N-1] == w_opb_x[N-1]) && (w_sum[N-1] != RD1_i[N-1]);
    case (ALUControl_i)
      2'b10: begin
        w_res = RD1_i & w_opb;
        w_c   = 1'b0;
        w_v   = 1'b0;
      end
      2'b11: begin
        w_res = RD1_i | w_opb;
        w_c   = 1'b0;
        w_v   = 1'b0;
      end
      default: ;
    endcase
  end

  // Condition uses the committed flags only; this instruction's own SetFlags is not visible yet.
  always_comb begin
    w_cond = 1'b0;
    case (A3_i)
      4'd0:    w_cond = 1'b1;
      4'd1:    w_cond = r_flags[2];
      4'd2:    w_cond = ~r_flags[2];
      4'd3:    w_cond = r_flags[3] ^ r_flags[0];
      4'd4:    w_cond = ~(r_flags[3] ^ r_flags[0]);
      default: w_cond = 1'b0;
    endcase
  end

  assign BranchTaken_o  = RST & Valid_i & BranchSelect_i & w_cond & ~Stall_i;
  assign BranchTarget_o = Extend_i;
  assign Flags_o        = r_flags;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_flags <= 4'b0000;
    end else if (Valid_i && SetFlags_i && !Stall_i) begin
      r_flags <= {w_res[N-1], (w_res == '0), w_c, w_v};
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ALUResult_o <= '0;
      WriteData_o <= '0;
      A3_o        <= 4'd0;
      RF_WE_o     <= 1'b0;
      MemWE_o     <= 1'b0;
      WBSelect_o  <= 1'b0;
      Valid_o     <= 1'b0;
    end else if (!Stall_i) begin
      ALUResult_o <= w_res;
      WriteData_o <= RD2_i;
      A3_o        <= A3_i;
      RF_WE_o     <= RF_WE_i & Valid_i;
      MemWE_o     <= MemWE_i & Valid_i;
      WBSelect_o  <= WBSelect_i;
      Valid_o     <= Valid_i;
    end
  end

endmodule

// File: tb/tb_stage_ex.sv
// tb/tb_stage_ex.sv - self-checking bench for stage_ex against an arithmetic reference model
module tb_stage_ex;

  logic        CLK = 1'b0;
  logic        RST;
  logic        Stall_i, Valid_i;
  logic [31:0] RD1_i, RD2_i, Extend_i;
  logic [3:0]  A3_i;
  logic        RF_WE_i, MemWE_i, WBSelect_i, SetFlags_i, BranchSelect_i, ALUOpBSelect_i;
  logic [1:0]  ALUControl_i;
  logic        BranchTaken_o;
  logic [31:0] BranchTarget_o, ALUResult_o, WriteData_o;
  logic [3:0]  A3_o;
  logic        RF_WE_o, MemWE_o, WBSelect_o, Valid_o;
  logic [3:0]  Flags_o;

  stage_ex #(.N(32)) dut (
    .CLK(CLK), .RST(RST), .Stall_i(Stall_i), .Valid_i(Valid_i),
    .RD1_i(RD1_i), .RD2_i(RD2_i), .Extend_i(Extend_i), .A3_i(A3_i),
    .RF_WE_i(RF_WE_i), .MemWE_i(MemWE_i), .WBSelect_i(WBSelect_i), .SetFlags_i(SetFlags_i),
    .BranchSelect_i(BranchSelect_i), .ALUOpBSelect_i(ALUOpBSelect_i), .ALUControl_i(ALUControl_i),
    .BranchTaken_o(BranchTaken_o), .BranchTarget_o(BranchTarget_o), .ALUResult_o(ALUResult_o),
    .WriteData_o(WriteData_o), .A3_o(A3_o), .RF_WE_o(RF_WE_o), .MemWE_o(MemWE_o),
    .WBSelect_o(WBSelect_o), .Valid_o(Valid_o), .Flags_o(Flags_o)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [31:0] m_alu, m_wd;
  logic [3:0]  m_a3, m_flags;
  logic        m_rfwe, m_memwe, m_wbsel, m_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_alu = 0; m_wd = 0; m_a3 = 0; m_flags = 0;
    m_rfwe = 0; m_memwe = 0; m_wbsel = 0; m_valid = 0;
  endtask

  task automatic ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                         output logic [31:0] res, output logic [3:0] f);
    longint sr;
    logic c, v;
    c = 0; v = 0; res = 0;
    case (op)
      2'd0: begin
        res = a + b;
        c   = (longint'(a) + longint'(b)) > 64'sd4294967295;
        sr  = longint'($signed(a)) + longint'($signed(b));
        v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      2'd1: begin
        res = a - b;
        c   = (a >= b);
        sr  = longint'($signed(a)) - longint'($signed(b));
        v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      2'd2: res = a & b;
      default: res = a | b;
    endcase
    f = {res[31], res == 32'd0, c, v};
  endtask

  function automatic logic cond_met(input logic [3:0] f, input logic [3:0] cc);
    case (cc)
      4'd0: return 1'b1;
      4'd1: return f[2];
      4'd2: return !f[2];
      4'd3: return f[3] != f[0];
      4'd4: return f[3] == f[0];
      default: return 1'b0;
    endcase
  endfunction

  task automatic check_regs();
    chk("alu_result", ALUResult_o, m_alu);
    chk("write_data", WriteData_o, m_wd);
    chk("a3", {28'd0, A3_o}, {28'd0, m_a3});
    chk("rf_we", {31'd0, RF_WE_o}, {31'd0, m_rfwe});
    chk("mem_we", {31'd0, MemWE_o}, {31'd0, m_memwe});
    chk("wb_sel", {31'd0, WBSelect_o}, {31'd0, m_wbsel});
    chk("valid", {31'd0, Valid_o}, {31'd0, m_valid});
    chk("flags", {28'd0, Flags_o}, {28'd0, m_flags});
  endtask

  // Inputs are set after a falling edge; this checks the combinational branch, clocks once, checks registers.
  task automatic step();
    logic [31:0] res;
    logic [3:0]  f;
    #1;
    chk("branch_taken", {31'd0, BranchTaken_o},
        {31'd0, Valid_i & BranchSelect_i & cond_met(m_flags, A3_i) & !Stall_i});
    chk("branch_target", BranchTarget_o, Extend_i);
    @(posedge CLK);
    if (!Stall_i) begin
      ref_alu(RD1_i, ALUOpBSelect_i ? Extend_i : RD2_i, ALUControl_i, res, f);
      if (Valid_i && SetFlags_i) m_flags = f;
      m_alu = res; m_wd = RD2_i; m_a3 = A3_i; m_wbsel = WBSelect_i; m_valid = Valid_i;
      m_rfwe = RF_WE_i & Valid_i; m_memwe = MemWE_i & Valid_i;
    end
    #1;
    check_regs();
    @(negedge CLK);
  endtask

  task automatic set_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ext,
                        input logic [1:0] op, input logic bsel_imm, input logic [3:0] a3,
                        input logic setf, input logic br);
    RD1_i = a; RD2_i = b; Extend_i = ext; ALUControl_i = op; ALUOpBSelect_i = bsel_imm;
    A3_i = a3; SetFlags_i = setf; BranchSelect_i = br;
    Valid_i = 1; Stall_i = 0; RF_WE_i = !br; MemWE_i = 0; WBSelect_i = 0;
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return $urandom_range(0, 16);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    // reset with non-zero inputs, including an unconditional branch
    RST = 0;
    set_op(32'h1234, 32'h5678, 32'h9ABC, 2'd0, 0, 4'd0, 1, 1);
    model_reset();
    #12;
    check_regs();
    chk("reset_branch_taken", {31'd0, BranchTaken_o}, 32'd0);
    @(negedge CLK);
    RST = 1;

    // add register operands
    set_op(32'd1, 32'd2, 32'd0, 2'd0, 0, 4'd3, 0, 0);
    step();
    chk("add_reg_result", ALUResult_o, 32'd3);

    // add immediate with signed overflow
    set_op(32'h7FFF_FFFF, 32'd0, 32'd1, 2'd0, 1, 4'd4, 1, 0);
    step();
    chk("add_imm_result", ALUResult_o, 32'h8000_0000);
    chk("add_imm_flags", {28'd0, Flags_o}, 32'b1001);

    // CMP equal then BEQ / BNE
    set_op(32'd5, 32'd5, 32'd0, 2'd1, 0, 4'd0, 1, 0);
    step();
    chk("cmp_flags", {28'd0, Flags_o}, 32'b0110);
    set_op(32'd0, 32'd0, 32'h40, 2'd0, 1, 4'd1, 0, 1);
    #1;
    chk("beq_taken", {31'd0, BranchTaken_o}, 32'd1);
    chk("beq_target", BranchTarget_o, 32'h40);
    step();
    set_op(32'd0, 32'd0, 32'h40, 2'd0, 1, 4'd2, 0, 1);
    step();

    // stall holds registers and flags and suppresses a taken branch
    set_op(32'd4, 32'd5, 32'd0, 2'd0, 0, 4'd6, 0, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      set_op(32'd100 + i, 32'd7, 32'h80, 2'd1, 0, 4'd0, 1, 1);
      Stall_i = 1;
      step();
      chk("stall_hold", ALUResult_o, 32'd9);
      chk("stall_flags", {28'd0, Flags_o}, 32'b0110);
    end

    // bubble with control bits set
    set_op(32'd0, 32'd0, 32'd0, 2'd1, 0, 4'd0, 1, 1);
    Valid_i = 0; RF_WE_i = 1; MemWE_i = 1;
    step();
    chk("bubble_valid", {31'd0, Valid_o}, 32'd0);
    chk("bubble_flags", {28'd0, Flags_o}, 32'b0110);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      RD1_i = pick_val(); RD2_i = pick_val(); Extend_i = pick_val();
      A3_i = 4'($urandom_range(0, 15));
      ALUControl_i = 2'($urandom_range(0, 3));
      ALUOpBSelect_i = 1'($urandom_range(0, 1));
      SetFlags_i = 1'($urandom_range(0, 1));
      BranchSelect_i = ($urandom_range(0, 3) == 0);
      RF_WE_i = 1'($urandom_range(0, 1));
      MemWE_i = 1'($urandom_range(0, 1));
      WBSelect_i = 1'($urandom_range(0, 1));
      Valid_i = ($urandom_range(0, 4) != 0);
      Stall_i = ($urandom_range(0, 4) == 0);
      step();
    end

    // reset asserted mid-operation clears immediately
    set_op(32'd3, 32'd9, 32'h10, 2'd1, 0, 4'd0, 1, 1);
    RST = 0;
    model_reset();
    #1;
    check_regs();
    chk("midreset_branch_taken", {31'd0, BranchTaken_o}, 32'd0);
    @(negedge CLK);
    RST = 1;
    set_op(32'd3, 32'd9, 32'h10, 2'd1, 0, 4'd4, 1, 1);
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
